// File: rtl/itcm_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : itcm_arbiter
// Brief    : Two-port (fetch I / load D) read arbiter for the 1-cycle ITCM.
//            Define ITCM_ARB_RR_EN for round-robin instead of fixed priority.
// Revision : 1.0
// ============================================================================
module itcm_arbiter #(
    parameter int STARVE_MAX = 3,
    parameter int AW         = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [31:0]   i_rdata,
    output logic          i_err,
    input  logic          d_req,
    input  logic [AW-1:0] d_addr,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [31:0]   d_rdata,
    output logic          d_err,
    output logic [AW-1:0] mem_addr,
    input  logic [31:0]   mem_rdata,
    input  logic          mem_ack
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_WAIT  = 2'd1;
    localparam logic [1:0] c_RESP  = 2'd2;
    localparam logic       c_OWN_I = 1'b0;
    localparam logic       c_OWN_D = 1'b1;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic          r_owner;
    logic [AW-1:0] r_mem_addr;
    logic          r_err_q;
    logic          w_accept;
    logic          w_pick_d;
    logic          w_gnt_i;
    logic          w_gnt_d;
    logic [AW-1:0] w_win_addr;

    assign w_accept = (r_state == c_IDLE) || (r_state == c_RESP);

`ifdef ITCM_ARB_RR_EN
    // Last winner starts as D so that I takes the first contention.
    logic r_last;

    assign w_pick_d = d_req && (!i_req || (r_last == c_OWN_I));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= c_OWN_D;
        end else if (w_gnt_d) begin
            r_last <= c_OWN_D;
        end else if (w_gnt_i) begin
            r_last <= c_OWN_I;
        end
    end
`else
    localparam int              c_SW         = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [c_SW-1:0] c_STARVE_MAX = c_SW'(STARVE_MAX);

    logic [c_SW-1:0] r_starve;

    // D has priority until I has lost STARVE_MAX arbitrations in a row.
    assign w_pick_d = d_req && (!i_req || (r_starve != c_STARVE_MAX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve <= '0;
        end else if (w_gnt_d) begin
            if (!i_req) begin
                r_starve <= '0;
            end else if (r_starve != c_STARVE_MAX) begin
                r_starve <= r_starve + 1'b1;
            end
        end else if (w_gnt_i) begin
            r_starve <= '0;
        end
    end
`endif

    assign w_gnt_d    = w_accept && w_pick_d;
    assign w_gnt_i    = w_accept && i_req && !w_pick_d;
    assign w_win_addr = w_gnt_d ? d_addr : i_addr;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_gnt_i || w_gnt_d) w_state_nxt = c_WAIT;
            c_WAIT:  if (mem_ack) w_state_nxt = c_RESP;
            c_RESP:  w_state_nxt = (w_gnt_i || w_gnt_d) ? c_WAIT : c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_owner    <= c_OWN_I;
            r_mem_addr <= '0;
            r_err_q    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_gnt_i || w_gnt_d) begin
                r_mem_addr <= w_win_addr;
                r_owner    <= w_gnt_d ? c_OWN_D : c_OWN_I;
                r_err_q    <= |w_win_addr[1:0];
            end
        end
    end

    assign i_gnt    = w_gnt_i;
    assign d_gnt    = w_gnt_d;
    assign i_rvalid = (r_state == c_RESP) && (r_owner == c_OWN_I);
    assign d_rvalid = (r_state == c_RESP) && (r_owner == c_OWN_D);
    assign i_err    = i_rvalid && r_err_q;
    assign d_err    = d_rvalid && r_err_q;
    assign i_rdata  = mem_rdata;
    assign d_rdata  = mem_rdata;
    assign mem_addr = r_mem_addr;

endmodule
`default_nettype wire

// File: doc/itcm_arbiter.md
Name: itcm_arbiter

Overview:
- Two-port read arbiter in front of the single-ported, 1-cycle-latency ITCM (4 KB, word-addressed by addr[11:2]).
- Shares the ITCM between the instruction-fetch port (port I) and the data-side load port (port D), so the core can read constants and literal pools out of ITCM.
- Sequences each access as issue, wait, response. Returns data and a misalignment flag to the requester that won arbitration.

Parameters:
- STARVE_MAX, 3: consecutive arbitrations port I may lose while requesting before it is forced to win.
- AW, 32: address width of both ports and the memory address bus.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  asynchronous, active-high reset
- i_req  input  1  port I request; held with i_addr stable until i_gnt
- i_addr  input  AW  port I byte address
- i_gnt  output  1  combinational; request accepted this cycle
- i_rvalid  output  1  one-cycle response strobe for port I
- i_rdata  output  32  response data; valid only when i_rvalid
- i_err  output  1  with i_rvalid: address was misaligned (addr[1:0] != 0)
- d_req, d_addr, d_gnt, d_rvalid, d_rdata, d_err: same as port I, for port D
- mem_addr  output  AW  registered address to ITCM
- mem_rdata  input  32  ITCM data_out
- mem_ack  input  1  ITCM ack

Behaviour:
- Reset values:
  - state = IDLE, owner = I, starve_cnt = 0, mem_addr = 0, err_q = 0.
  - All gnt, rvalid and err outputs = 0.
  - rdata outputs = mem_rdata pass-through.
- States:
  - IDLE: no access in flight.
  - WAIT: ITCM samples mem_addr on this cycle's edge.
  - RESP: mem_rdata is valid.
- Accept window: a grant can be issued in IDLE or RESP. At most one gnt is high per cycle.
- On a grant at edge E0:
  - mem_addr <= winner addr.
  - owner <= winner.
  - err_q <= (addr[1:0] != 0).
  - state <= WAIT.
- WAIT to RESP:
  - WAIT goes to RESP when mem_ack = 1.
  - While mem_ack = 0, stay in WAIT and hold mem_addr.
- RESP outputs:
  - owner_rvalid = 1 and owner_err = err_q.
  - Both rdata outputs = mem_rdata.
- RESP exit:
  - If a new grant is issued in RESP: next state = WAIT.
  - Otherwise: next state = IDLE.
- Latency: gnt in cycle N, rvalid in cycle N+2 (mem_ack high). Maximum throughput is one access per 2 cycles.
- Misaligned access: the memory still reads the word at addr[11:2]. err flags it; the arbiter does not block or retry.
- Arbitration (default, fixed priority with anti-starvation):
  - D wins over I unless starve_cnt == STARVE_MAX, in which case I wins.
  - starve_cnt increments, saturating, on each grant to D while i_req = 1.
  - starve_cnt clears on any grant to I, and when i_req = 0 at a grant.
- A single requester always wins immediately.
- Upper address bits above [11:2] are ignored; no out-of-range error.
- Requesters must not drop req before gnt. Dropping req early means no grant and no response.
- Reset asserted mid-operation: immediate return to IDLE. The in-flight response is discarded and no rvalid is produced. starve_cnt and owner are cleared.

Optional Feature:
- ITCM_ARB_RR_EN defined:
  - Round-robin arbitration replaces the fixed-priority scheme. The port that did not win the last grant wins on contention.
  - The last-winner register resets to D, so I wins the first contention.
  - starve_cnt logic is not compiled.
- ITCM_ARB_RR_EN undefined: fixed-priority plus STARVE_MAX anti-starvation as above.

Test Plan:
- Single I access: i_req=1, i_addr=0x8, mem word 2 = 0x00202023 -> i_gnt same cycle; i_rvalid=1 two cycles later with i_rdata=0x00202023, i_err=0; d_rvalid stays 0.
- Simultaneous requests: i_addr=0x0, d_addr=0x4 -> d_gnt first, then i_gnt in D's RESP cycle; responses back-to-back two cycles apart: D gets 0x00100113's neighbour 0x00400113, then I gets 0x00100113.
- Starvation, STARVE_MAX=3: d_req held high continuously, i_req high -> D wins 3 grants, 4th grant goes to I, then D resumes.
- Misaligned: d_addr=0x0A -> d_rvalid with d_err=1 and d_rdata = word 2 (0x00202023).
- mem_ack held 0 for 3 cycles after issue -> arbiter stays in WAIT, mem_addr stable, no rvalid; rvalid one cycle after mem_ack rises.
- rst pulsed while in WAIT -> no rvalid, all outputs reset, next request served normally. With ITCM_ARB_RR_EN, continuous contention alternates grants I, D, I, D.
